// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory stage.
package lsu_pkg;

   // FSM states of the memory stage
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

   // Access size encodings as carried on mem_size_i
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
   localparam logic [1:0] SIZE_D = 2'd3;

   // Widest supported datapath; narrower instances zero-extend into these fields
   localparam int MAX_XLEN = 64;
   localparam int MAX_NB   = MAX_XLEN / 8;

   // One recent-store history entry (word-aligned address, lane enables, lane data)
   typedef struct packed {
      logic                valid;
      logic [MAX_XLEN-1:0] waddr;
      logic [MAX_NB-1:0]   be;
      logic [MAX_XLEN-1:0] data;
   } fwd_entry_t;

   // Unshifted byte-enable mask for an access size
   function automatic logic [MAX_NB-1:0] be_mask(input logic [1:0] size);
      logic [MAX_NB-1:0] m;
      case (size)
         SIZE_B:  m = 8'h01;
         SIZE_H:  m = 8'h03;
         SIZE_W:  m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   // Move the addressed lane down to bit 0, then sign- or zero-extend it
   function automatic logic [MAX_XLEN-1:0] lane_extend(input logic [MAX_XLEN-1:0] word,
                                                       input logic [2:0]          offset,
                                                       input logic [1:0]          size,
                                                       input logic                is_unsigned);
      logic [MAX_XLEN-1:0] sh;
      logic [MAX_XLEN-1:0] res;
      sh = word >> {offset, 3'b000};
      case (size)
         SIZE_B:  res = is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}}, sh[7:0]};
         SIZE_H:  res = is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         SIZE_W:  res = is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/lsu_fwd_buf.sv
// Recent-store history: a circular buffer of completed stores, and a per-lane
// merge that overlays the youngest matching store bytes onto memory read data.
module lsu_fwd_buf
   import lsu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              push_i,
   input  logic [XLEN-1:0]   push_addr_i,
   input  logic [XLEN/8-1:0] push_be_i,
   input  logic [XLEN-1:0]   push_data_i,
   input  logic [XLEN-1:0]   lookup_addr_i,
   input  logic [XLEN-1:0]   mem_data_i,
   output logic [XLEN-1:0]   merged_o
);

   localparam int NB    = XLEN / 8;
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fwd_entry_t        hist_q [DEPTH];
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [PTR_W-1:0]  idx;
   logic              unused_hist;

   // Write pointer always names the oldest slot, which the next push overwrites
   always_comb begin
      ptr_d = ptr_q;
      if (push_i) begin
         ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   // History storage; reset invalidates every entry
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         ptr_q <= ptr_d;
         if (push_i) begin
            hist_q[ptr_q] <= '{valid: 1'b1,
                               waddr: MAX_XLEN'(push_addr_i),
                               be:    MAX_NB'(push_be_i),
                               data:  MAX_XLEN'(push_data_i)};
         end
      end
   end

   // Walk oldest to youngest so the youngest matching byte wins each lane
   always_comb begin
      merged_o = mem_data_i;
      idx      = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = PTR_W'((int'(ptr_q) + k) % DEPTH);
         if (hist_q[idx].valid && (hist_q[idx].waddr == MAX_XLEN'(lookup_addr_i))) begin
            for (int b = 0; b < NB; b++) begin
               if (hist_q[idx].be[b]) begin
                  merged_o[8*b +: 8] = hist_q[idx].data[8*b +: 8];
               end
            end
         end
      end
   end

   // Fold the width-padding bits of narrow instances into one ignored net
   always_comb begin
      unused_hist = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         unused_hist = unused_hist ^ (^hist_q[k]);
      end
   end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access pipeline stage between execute and writeback. Issues byte/half/
// word/dword accesses over a req/gnt/rvalid interface, extends loads, and
// forwards bytes from recent stores.
//
// Handshakes: an op moves from execute when in_valid_i && in_ready_o at a
// rising edge. A memory request is offered while dmem_req_o is high and is
// taken at the edge where dmem_gnt_i is also high; the request fields do not
// change until then. Load data is taken at the first edge with dmem_rvalid_i
// high strictly after the grant edge. rd_valid_o is a one-cycle strobe with no
// back-pressure.
module lsu_mem_stage
   import lsu_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_AW    = 5,
   parameter int FWD_DEPTH = 4,
   parameter int WARMUP    = 3
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              halt_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [XLEN-1:0]   mem_addr_i,
   input  logic              mem_read_en_i,
   input  logic              mem_write_en_i,
   input  logic [XLEN-1:0]   mem_write_data_i,
   input  logic [1:0]        mem_size_i,
   input  logic              load_unsigned_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   input  logic              rd_write_en_i,
   input  logic [XLEN-1:0]   rd_data_i,
   output logic              dmem_req_o,
   input  logic              dmem_gnt_i,
   output logic              dmem_we_o,
   output logic [XLEN-1:0]   dmem_addr_o,
   output logic [XLEN/8-1:0] dmem_be_o,
   output logic [XLEN-1:0]   dmem_wdata_o,
   input  logic              dmem_rvalid_i,
   input  logic [XLEN-1:0]   dmem_rdata_i,
   output logic              rd_valid_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic              rd_write_en_o,
   output logic [XLEN-1:0]   rd_data_o,
   output logic              misalign_o,
   output lsu_state_e        dbg_state_o
);

   localparam int NB     = XLEN / 8;
   localparam int OFF_W  = $clog2(NB);
   localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

   lsu_state_e        state_q, state_d;
   logic [WCNT_W-1:0] warm_q, warm_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [OFF_W-1:0]  off_q, off_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [NB-1:0]     be_q, be_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
   logic              rd_we_q, rd_we_d;
   logic [XLEN-1:0]   rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              misalign_q, misalign_d;

   logic                warm;
   logic                accept;
   logic                is_mem;
   logic                misaligned;
   logic [OFF_W-1:0]    in_off;
   logic [MAX_NB-1:0]   mask8;
   logic [NB-1:0]       be_new;
   logic [XLEN-1:0]     wdata_new;
   logic [XLEN-1:0]     waddr_new;
   logic                push;
   logic [XLEN-1:0]     merged_data;
   logic [MAX_XLEN-1:0] ext_full;
   logic [XLEN-1:0]     load_data;
   logic                unused_bits;

   assign warm       = (warm_q == WCNT_W'(WARMUP));
   assign in_ready_o = (state_q == ST_IDLE) & warm & ~halt_i;
   assign accept     = in_valid_i & in_ready_o;
   assign is_mem     = mem_read_en_i | mem_write_en_i;
   assign in_off     = mem_addr_i[OFF_W-1:0];
   assign waddr_new  = {mem_addr_i[XLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign mask8      = be_mask(mem_size_i);
   assign be_new     = NB'(mask8) << in_off;

   // Misalignment check; a dword on a 32-bit datapath is rejected the same way
   always_comb begin
      case (mem_size_i)
         SIZE_H:  misaligned = mem_addr_i[0];
         SIZE_W:  misaligned = |mem_addr_i[1:0];
         SIZE_D:  misaligned = (XLEN < 64) ? 1'b1 : (|mem_addr_i[2:0]);
         default: misaligned = 1'b0;
      endcase
   end

   // Replicate store data into every lane so memory picks it up under be
   always_comb begin
      case (mem_size_i)
         SIZE_B:  wdata_new = {NB{mem_write_data_i[7:0]}};
         SIZE_H:  wdata_new = {(NB/2){mem_write_data_i[15:0]}};
         SIZE_W:  wdata_new = {(NB/4){mem_write_data_i[31:0]}};
         default: wdata_new = mem_write_data_i;
      endcase
   end

   lsu_fwd_buf #(
      .XLEN  (XLEN),
      .DEPTH (FWD_DEPTH)
   ) u_fwd_buf (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .push_i        (push),
      .push_addr_i   (addr_q),
      .push_be_i     (be_q),
      .push_data_i   (wdata_q),
      .lookup_addr_i (addr_q),
      .mem_data_i    (dmem_rdata_i),
      .merged_o      (merged_data)
   );

   assign ext_full    = lane_extend(MAX_XLEN'(merged_data), 3'(off_q), size_q, uns_q);
   assign load_data   = ext_full[XLEN-1:0];
   assign unused_bits = ^{ext_full, mask8};

   // Warm-up counter saturates, after which the stage may accept work
   always_comb begin
      warm_d = warm ? warm_q : warm_q + WCNT_W'(1);
   end

   // Next state, field capture and writeback strobes
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      off_d      = off_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rd_addr_d  = rd_addr_q;
      rd_we_d    = rd_we_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      misalign_d = 1'b0;
      push       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               rd_addr_d = rd_addr_i;
               if (!is_mem) begin
                  rd_valid_d = 1'b1;
                  rd_we_d    = rd_write_en_i;
                  rd_data_d  = rd_data_i;
               end else if (misaligned) begin
                  rd_valid_d = 1'b1;
                  rd_we_d    = 1'b0;
                  rd_data_d  = '0;
                  misalign_d = 1'b1;
               end else begin
                  // A write takes precedence when both enables are set
                  addr_d    = waddr_new;
                  off_d     = in_off;
                  we_d      = mem_write_en_i;
                  size_d    = mem_size_i;
                  uns_d     = load_unsigned_i;
                  be_d      = be_new;
                  wdata_d   = wdata_new;
                  rd_we_d   = rd_write_en_i & ~mem_write_en_i;
                  rd_data_d = '0;
                  state_d   = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (dmem_gnt_i) begin
               if (we_q) begin
                  push       = 1'b1;
                  rd_valid_d = 1'b1;
                  state_d    = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid_i) begin
               rd_data_d  = load_data;
               rd_valid_d = 1'b1;
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers, all cleared by the asynchronous reset
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         warm_q     <= '0;
         addr_q     <= '0;
         off_q      <= '0;
         we_q       <= 1'b0;
         size_q     <= '0;
         uns_q      <= 1'b0;
         be_q       <= '0;
         wdata_q    <= '0;
         rd_addr_q  <= '0;
         rd_we_q    <= 1'b0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         warm_q     <= warm_d;
         addr_q     <= addr_d;
         off_q      <= off_d;
         we_q       <= we_d;
         size_q     <= size_d;
         uns_q      <= uns_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rd_addr_q  <= rd_addr_d;
         rd_we_q    <= rd_we_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         misalign_q <= misalign_d;
      end
   end

   assign dmem_req_o    = (state_q == ST_REQ);
   assign dmem_we_o     = we_q;
   assign dmem_addr_o   = addr_q;
   assign dmem_be_o     = be_q;
   assign dmem_wdata_o  = wdata_q;
   assign rd_valid_o    = rd_valid_q;
   assign rd_addr_o     = rd_addr_q;
   assign rd_write_en_o = rd_we_q;
   assign rd_data_o     = rd_data_q;
   assign misalign_o    = misalign_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed testbench for lsu_mem_stage (XLEN=32, FWD_DEPTH=4, WARMUP=3).
module tb_lsu_mem_stage;
   import lsu_pkg::*;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        halt_i;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [31:0] mem_addr_i;
   logic        mem_read_en_i;
   logic        mem_write_en_i;
   logic [31:0] mem_write_data_i;
   logic [1:0]  mem_size_i;
   logic        load_unsigned_i;
   logic [4:0]  rd_addr_i;
   logic        rd_write_en_i;
   logic [31:0] rd_data_i;
   logic        dmem_req_o;
   logic        dmem_gnt_i;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_rvalid_i;
   logic [31:0] dmem_rdata_i;
   logic        rd_valid_o;
   logic [4:0]  rd_addr_o;
   logic        rd_write_en_o;
   logic [31:0] rd_data_o;
   logic        misalign_o;
   lsu_state_e  dbg_state_o;

   logic [109:0] outs;
   assign outs = {dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
                  rd_valid_o, rd_addr_o, rd_write_en_o, rd_data_o, misalign_o};

   int checks = 0;
   int errors = 0;

   // Clock and watchdog
   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   lsu_mem_stage #(
      .XLEN(32), .REG_AW(5), .FWD_DEPTH(4), .WARMUP(3)
   ) dut (
      .clk_i            (clk_i),
      .reset_i          (reset_i),
      .halt_i           (halt_i),
      .in_valid_i       (in_valid_i),
      .in_ready_o       (in_ready_o),
      .mem_addr_i       (mem_addr_i),
      .mem_read_en_i    (mem_read_en_i),
      .mem_write_en_i   (mem_write_en_i),
      .mem_write_data_i (mem_write_data_i),
      .mem_size_i       (mem_size_i),
      .load_unsigned_i  (load_unsigned_i),
      .rd_addr_i        (rd_addr_i),
      .rd_write_en_i    (rd_write_en_i),
      .rd_data_i        (rd_data_i),
      .dmem_req_o       (dmem_req_o),
      .dmem_gnt_i       (dmem_gnt_i),
      .dmem_we_o        (dmem_we_o),
      .dmem_addr_o      (dmem_addr_o),
      .dmem_be_o        (dmem_be_o),
      .dmem_wdata_o     (dmem_wdata_o),
      .dmem_rvalid_i    (dmem_rvalid_i),
      .dmem_rdata_i     (dmem_rdata_i),
      .rd_valid_o       (rd_valid_o),
      .rd_addr_o        (rd_addr_o),
      .rd_write_en_o    (rd_write_en_o),
      .rd_data_o        (rd_data_o),
      .misalign_o       (misalign_o),
      .dbg_state_o      (dbg_state_o)
   );

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_idle();
      halt_i           = 1'b0;
      in_valid_i       = 1'b0;
      mem_addr_i       = '0;
      mem_read_en_i    = 1'b0;
      mem_write_en_i   = 1'b0;
      mem_write_data_i = '0;
      mem_size_i       = '0;
      load_unsigned_i  = 1'b0;
      rd_addr_i        = '0;
      rd_write_en_i    = 1'b0;
      rd_data_i        = '0;
      dmem_gnt_i       = 1'b0;
      dmem_rvalid_i    = 1'b0;
      dmem_rdata_i     = '0;
   endtask

   task automatic drive_alu(input logic [4:0] ra, input logic [31:0] data);
      in_valid_i     = 1'b1;
      mem_read_en_i  = 1'b0;
      mem_write_en_i = 1'b0;
      rd_addr_i      = ra;
      rd_write_en_i  = 1'b1;
      rd_data_i      = data;
   endtask

   task automatic drive_mem(input logic we, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wdata);
      in_valid_i       = 1'b1;
      mem_read_en_i    = ~we;
      mem_write_en_i   = we;
      mem_addr_i       = addr;
      mem_size_i       = size;
      load_unsigned_i  = uns;
      mem_write_data_i = wdata;
      rd_addr_i        = 5'd7;
      rd_write_en_i    = 1'b1;
      rd_data_i        = '0;
   endtask

   task automatic release_reset();
      @(negedge clk_i);
      reset_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
   endtask

   // Full memory transaction: gnt after gnt_wait stalled cycles (halt_i held at
   // halt_wait meanwhile); for loads a bogus rvalid rides the grant cycle and the
   // real data arrives rv_wait cycles after grant. Returns what was observed.
   task automatic run_mem(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata,
                          input int gnt_wait, input logic halt_wait,
                          input int rv_wait, input logic [31:0] rdata,
                          output logic [31:0] r_data, output logic r_we, output int r_lat,
                          output logic r_stable, output logic [31:0] r_addr,
                          output logic [3:0] r_be, output logic [31:0] r_wdata);
      r_data = 'x;
      r_we   = 1'bx;
      drive_mem(we, addr, size, uns, wdata);
      tick();
      drive_idle();
      @(negedge clk_i);
      r_addr   = dmem_addr_o;
      r_be     = dmem_be_o;
      r_wdata  = dmem_wdata_o;
      r_stable = dmem_req_o & (dmem_we_o == we);
      halt_i   = halt_wait;
      for (int i = 0; i < gnt_wait; i++) begin
         tick();
         @(negedge clk_i);
         if (!dmem_req_o || dmem_addr_o !== r_addr || dmem_be_o !== r_be ||
             dmem_wdata_o !== r_wdata || dmem_we_o !== we) r_stable = 1'b0;
      end
      dmem_gnt_i = 1'b1;
      if (!we) begin
         dmem_rvalid_i = 1'b1;
         dmem_rdata_i  = 32'hDEAD_BEEF;
      end
      tick();
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      dmem_rdata_i  = '0;
      halt_i        = 1'b0;
      if (!we) begin
         for (int i = 1; i < rv_wait; i++) tick();
         dmem_rvalid_i = 1'b1;
         dmem_rdata_i  = rdata;
         tick();
         dmem_rvalid_i = 1'b0;
         dmem_rdata_i  = '0;
      end
      r_lat = -1;
      for (int i = 0; i < 8 && r_lat < 0; i++) begin
         @(negedge clk_i);
         if (rd_valid_o) begin
            r_lat  = i;
            r_data = rd_data_o;
            r_we   = rd_write_en_o;
         end
         tick();
      end
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      reset_i = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checks++;
      if (outs !== '0 || in_ready_o !== 1'b0)
         $display("FAIL reset_outputs: got %h/%b expected 0/0", outs, in_ready_o);
      if (outs !== '0 || in_ready_o !== 1'b0) errors++;
      checks++;
      if (dbg_state_o !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state_o, ST_IDLE);
      end
      reset_i = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk_i);
         checks++;
         if (in_ready_o !== (k == 3)) begin
            errors++;
            $display("FAIL warmup_ready[%0d]: got %b expected %b", k, in_ready_o, (k == 3));
         end
         checks++;
         if (outs !== '0) begin
            errors++;
            $display("FAIL warmup_outputs[%0d]: got %h expected 0", k, outs);
         end
      end
      tick();
   endtask

   task automatic test_passthrough();
      drive_alu(5'd5, 32'h11);
      @(negedge clk_i);
      checks++;
      if (in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL alu_ready: got %b expected 1", in_ready_o);
      end
      tick();
      drive_alu(5'd6, 32'h22);
      @(negedge clk_i);
      checks++;
      if ({rd_valid_o, rd_write_en_o, rd_addr_o, rd_data_o} !== {1'b1, 1'b1, 5'd5, 32'h11}) begin
         errors++;
         $display("FAIL alu_op1: got v%b we%b a%0d d%h expected v1 we1 a5 d00000011",
                  rd_valid_o, rd_write_en_o, rd_addr_o, rd_data_o);
      end
      tick();
      drive_idle();
      @(negedge clk_i);
      checks++;
      if ({rd_valid_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd6, 32'h22}) begin
         errors++;
         $display("FAIL alu_op2: got v%b a%0d d%h expected v1 a6 d00000022",
                  rd_valid_o, rd_addr_o, rd_data_o);
      end
      checks++;
      if (dmem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL alu_no_req: got %b expected 0", dmem_req_o);
      end
      tick();
      @(negedge clk_i);
      checks++;
      if (rd_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL alu_strobe_drop: got %b expected 0", rd_valid_o);
      end
      tick();
   endtask

   task automatic test_halt();
      halt_i = 1'b1;
      drive_alu(5'd9, 32'h33);
      @(negedge clk_i);
      checks++;
      if (in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL halt_ready: got %b expected 0", in_ready_o);
      end
      tick();
      drive_idle();
      @(negedge clk_i);
      checks++;
      if (rd_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL halt_no_accept: got %b expected 0", rd_valid_o);
      end
      tick();
   endtask

   task automatic test_load_extend();
      logic [31:0] d, a, wd;
      logic        we, st;
      logic [3:0]  be;
      int          lat;
      run_mem(1'b0, 32'h1003, SIZE_B, 1'b0, 32'h0, 0, 1'b0, 2, 32'h8000_0000, d, we, lat, st, a, be, wd);
      checks++;
      if (d !== 32'hFFFF_FF80 || lat !== 0) begin
         errors++;
         $display("FAIL load_signed_byte: got %h lat %0d expected ffffff80 lat 0", d, lat);
      end
      checks++;
      if (we !== 1'b1 || a !== 32'h1000) begin
         errors++;
         $display("FAIL load_fields: got we%b addr %h expected we1 addr 00001000", we, a);
      end
      run_mem(1'b0, 32'h1003, SIZE_B, 1'b1, 32'h0, 1, 1'b0, 2, 32'h8000_0000, d, we, lat, st, a, be, wd);
      checks++;
      if (d !== 32'h0000_0080 || lat !== 0) begin
         errors++;
         $display("FAIL load_unsigned_byte: got %h lat %0d expected 00000080 lat 0", d, lat);
      end
   endtask

   task automatic test_store_byte();
      logic [31:0] d, a, wd;
      logic        we, st;
      logic [3:0]  be;
      int          lat;
      run_mem(1'b1, 32'h1003, SIZE_B, 1'b0, 32'hA5, 3, 1'b1, 0, 32'h0, d, we, lat, st, a, be, wd);
      checks++;
      if (be !== 4'h8 || wd !== 32'hA5A5_A5A5 || a !== 32'h1000) begin
         errors++;
         $display("FAIL store_fields: got be %h wdata %h addr %h expected be 8 wdata a5a5a5a5 addr 00001000",
                  be, wd, a);
      end
      checks++;
      if (st !== 1'b1) begin
         errors++;
         $display("FAIL store_stable: got %b expected 1", st);
      end
      checks++;
      if (lat !== 0 || we !== 1'b0) begin
         errors++;
         $display("FAIL store_writeback: got lat %0d we %b expected lat 0 we 0", lat, we);
      end
   endtask

   task automatic test_forwarding();
      logic [31:0] d, a, wd;
      logic        we, st;
      logic [3:0]  be;
      int          lat;
      run_mem(1'b1, 32'h2002, SIZE_H, 1'b0, 32'hBEEF, 0, 1'b0, 0, 32'h0, d, we, lat, st, a, be, wd);
      checks++;
      if (be !== 4'hC || wd !== 32'hBEEF_BEEF) begin
         errors++;
         $display("FAIL store_half_fields: got be %h wdata %h expected be c wdata beefbeef", be, wd);
      end
      run_mem(1'b0, 32'h2000, SIZE_W, 1'b0, 32'h0, 0, 1'b0, 1, 32'h1234_5678, d, we, lat, st, a, be, wd);
      checks++;
      if (d !== 32'hBEEF_5678) begin
         errors++;
         $display("FAIL fwd_merge: got %h expected beef5678", d);
      end
      for (int k = 0; k < 4; k++) begin
         run_mem(1'b1, 32'h4000 + 32'(4 * k), SIZE_W, 1'b0, 32'h0, 0, 1'b0, 0, 32'h0,
                 d, we, lat, st, a, be, wd);
      end
      run_mem(1'b0, 32'h2000, SIZE_W, 1'b0, 32'h0, 0, 1'b0, 1, 32'h1234_5678, d, we, lat, st, a, be, wd);
      checks++;
      if (d !== 32'h1234_5678) begin
         errors++;
         $display("FAIL fwd_evicted: got %h expected 12345678", d);
      end
   endtask

   task automatic test_misaligned();
      drive_mem(1'b0, 32'h3001, SIZE_W, 1'b0, 32'h0);
      tick();
      drive_idle();
      @(negedge clk_i);
      checks++;
      if ({misalign_o, rd_valid_o, rd_write_en_o, dmem_req_o} !== 4'b1100) begin
         errors++;
         $display("FAIL misalign_flag: got mis%b v%b we%b req%b expected mis1 v1 we0 req0",
                  misalign_o, rd_valid_o, rd_write_en_o, dmem_req_o);
      end
      tick();
      @(negedge clk_i);
      checks++;
      if ({misalign_o, rd_valid_o, dmem_req_o} !== 3'b000) begin
         errors++;
         $display("FAIL misalign_one_cycle: got mis%b v%b req%b expected 000",
                  misalign_o, rd_valid_o, dmem_req_o);
      end
      tick();
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] d, a, wd;
      logic        we, st;
      logic [3:0]  be;
      int          lat;
      // Reset while a request is outstanding
      drive_mem(1'b0, 32'h7000, SIZE_W, 1'b0, 32'h0);
      tick();
      drive_idle();
      @(negedge clk_i);
      checks++;
      if (dmem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL req_before_reset: got %b expected 1", dmem_req_o);
      end
      reset_i = 1'b1;
      #1;
      checks++;
      if (dmem_req_o !== 1'b0 || dbg_state_o !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_in_req: got req %b state %0d expected req 0 state 0", dmem_req_o, dbg_state_o);
      end
      release_reset();
      // Reset while waiting for load data, with a store to the same word in history
      run_mem(1'b1, 32'h6000, SIZE_W, 1'b0, 32'hCAFE_F00D, 0, 1'b0, 0, 32'h0, d, we, lat, st, a, be, wd);
      drive_mem(1'b0, 32'h6000, SIZE_W, 1'b0, 32'h0);
      tick();
      drive_idle();
      @(negedge clk_i);
      dmem_gnt_i = 1'b1;
      tick();
      dmem_gnt_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (dbg_state_o !== ST_WAIT) begin
         errors++;
         $display("FAIL reach_wait: got %0d expected %0d", dbg_state_o, ST_WAIT);
      end
      reset_i = 1'b1;
      #1;
      checks++;
      if (dbg_state_o !== ST_IDLE || dmem_req_o !== 1'b0 || in_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_wait: got state %0d req %b ready %b expected 0 0 0",
                  dbg_state_o, dmem_req_o, in_ready_o);
      end
      release_reset();
      run_mem(1'b0, 32'h6000, SIZE_W, 1'b0, 32'h0, 0, 1'b0, 1, 32'h1111_1111, d, we, lat, st, a, be, wd);
      checks++;
      if (d !== 32'h1111_1111) begin
         errors++;
         $display("FAIL history_cleared: got %h expected 11111111", d);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset_i = 1'b1;
      drive_idle();
      test_reset();
      test_passthrough();
      test_halt();
      test_load_extend();
      test_store_byte();
      test_forwarding();
      test_misaligned();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Parametrised memory-access pipeline stage; successor to the fixed-latency memory stage.
- Sits between execute and writeback.
- Talks to data memory over a req/gnt/rvalid handshake with variable latency.
- Generates byte enables for byte/half/word stores, sign/zero-extends loads, and forwards from a FWD_DEPTH-entry recent-store history.

Parameters:
XLEN, 32, data/address width (32 or 64)
REG_AW, 5, register address width
FWD_DEPTH, 4, recent-store history entries (power of 2, >=1)
WARMUP, 3, cycles after reset release before the stage accepts work

Ports:
clk_i  in  1  system clock
reset_i  in  1  asynchronous active-high reset
halt_i  in  1  blocks acceptance of new ops
in_valid_i  in  1  op valid from execute
in_ready_o  out  1  stage can accept op
mem_addr_i  in  XLEN  byte address
mem_read_en_i  in  1  load op
mem_write_en_i  in  1  store op
mem_write_data_i  in  XLEN  store data (LSB-aligned)
mem_size_i  in  2  0=byte 1=half 2=word 3=dword (dword legal only if XLEN=64)
load_unsigned_i  in  1  zero-extend load
rd_addr_i  in  REG_AW  destination register
rd_write_en_i  in  1  destination write enable
rd_data_i  in  XLEN  ALU result for non-load ops
dmem_req_o  out  1  memory request
dmem_gnt_i  in  1  request accepted
dmem_we_o  out  1  write request
dmem_addr_o  out  XLEN  word-aligned address
dmem_be_o  out  XLEN/8  byte enables
dmem_wdata_o  out  XLEN  lane-shifted store data
dmem_rvalid_i  in  1  load data valid
dmem_rdata_i  in  XLEN  load data
rd_valid_o  out  1  writeback strobe (one cycle per op)
rd_addr_o  out  REG_AW  writeback register
rd_write_en_o  out  1  register write enable
rd_data_o  out  XLEN  writeback data
misalign_o  out  1  one-cycle misaligned-access flag

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; history entries invalid; warm-up counter 0.
- Warm-up: counter saturates at WARMUP; in_ready_o=0 until saturated.
- Acceptance: in_ready_o = (state==IDLE) & warm & !halt_i. Accept = in_valid_i & in_ready_o.
- FSM IDLE:
  - Accepted non-memory op: rd_valid_o=1 next cycle with registered rd fields; stay IDLE. Throughput is 1/cycle.
  - Accepted memory op: capture all fields.
    - If misaligned (half with addr[0]!=0, word with addr[1:0]!=0, dword with addr[2:0]!=0): next cycle misalign_o=1, rd_valid_o=1, rd_write_en_o=0; no memory request.
    - Otherwise go to REQ.
  - If read and write are both set, the op is a store.
- FSM REQ:
  - dmem_req_o=1. dmem_addr_o, dmem_we_o, dmem_be_o and dmem_wdata_o are held stable until dmem_gnt_i.
  - Store granted: push to history, then DONE.
  - Load granted: go to WAIT.
- FSM WAIT: on dmem_rvalid_i, capture merged data, then DONE. dmem_rvalid_i in the grant cycle itself is ignored; earliest is the next cycle.
- FSM DONE: rd_valid_o=1 for one cycle; return to IDLE.
- Latency: memory ops take at least 2 cycles (accept, then REQ) plus grant and rvalid wait, then DONE.
- Byte enables: be = size mask (1, 3, F, FF) << addr[log2(XLEN/8)-1:0]. wdata is replicated into lanes.
- Forwarding history:
  - Circular buffer of {valid, word addr, be, wdata}; the oldest entry is overwritten.
  - For a load, each byte lane takes data from the youngest valid entry with a matching word address and that be bit set; otherwise from dmem_rdata_i.
  - Merge happens in WAIT on rvalid.
- Load extend: the selected lane is shifted down. Sign-extend unless load_unsigned_i; word loads on XLEN=64 extend bit 31.
- Store writeback: rd_write_en_o is forced to 0.
- halt_i:
  - Blocks acceptance only.
  - An in-flight op completes; halt never drops dmem_req_o before grant.
- Reset mid-operation: immediate return to IDLE; dmem_req_o drops asynchronously; history is cleared.

Decomposition:
- Package lsu_pkg:
  - state enum (IDLE, REQ, WAIT, DONE)
  - size encodings
  - be_mask function
  - lane shift/extend function
  - history entry struct
- Sub-module lsu_fwd_buf: history storage plus per-lane youngest-match merge.
  - Inputs: push, addr, be, data, lookup addr, mem data.
  - Output: merged data.

Test Plan:
- Reset then idle: in_ready_o=0 for 3 cycles after reset_i falls, 1 on the 4th; all outputs 0 throughout.
- ALU passthrough: consecutive ops rd_data_i=0x11,0x22 with rd_addr_i=5,6 -> rd_valid_o on consecutive cycles, data 0x11,0x22.
- Byte store at 0x1003, data 0xA5:
  - Expect dmem_be_o=0x8 and dmem_wdata_o=0xA5A5A5A5.
  - Hold gnt low for 3 cycles -> request fields stable throughout.
  - rd_valid_o with rd_write_en_o=0 one cycle after grant.
- Signed byte load at 0x1003, memory returning 0x80000000 2 cycles after grant -> rd_data_o=0xFFFFFF80; with load_unsigned_i=1 -> 0x00000080.
- Forwarding:
  - Store half 0xBEEF at 0x2002, then word load at 0x2000 with memory returning 0x12345678 -> rd_data_o=0xBEEF5678.
  - After FWD_DEPTH more stores to other addresses, the same load returns 0x12345678.
- Misaligned word load at 0x3001 -> misalign_o=1 and rd_valid_o=1 next cycle, dmem_req_o stays 0.
- Assert reset_i while in WAIT -> dmem_req_o=0 and FSM in IDLE immediately; history cleared.
